// File: rtl/sdram_port_req_queue.sv
// Request queue in front of one SDRAM controller port: buffers read/write
// commands in a small FIFO, issues them one at a time and returns read data in order.
module sdram_port_req_queue #(
    parameter int PORT_ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH        = 16,
    parameter int DQM_WIDTH         = 2,
    parameter int PORT_OUTPUT_WIDTH = DATA_WIDTH*2,
    parameter int DEPTH             = 4,
    parameter int TIMEOUT           = 1023
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [PORT_ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]        req_data,
    input  logic [DQM_WIDTH-1:0]         req_be,
    output logic                         rsp_valid,
    output logic [PORT_OUTPUT_WIDTH-1:0] rsp_data,
    output logic [PORT_ADDR_WIDTH-1:0]   p_addr,
    output logic [DATA_WIDTH-1:0]        p_data,
    output logic [DQM_WIDTH-1:0]         p_byte_en,
    output logic                         p_wr,
    output logic                         p_rd,
    input  logic [PORT_OUTPUT_WIDTH-1:0] p_q,
    input  logic                         p_available,
    input  logic                         p_ready,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         busy,
    output logic                         err_timeout
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic                       we;
        logic [PORT_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]      data;
        logic [DQM_WIDTH-1:0]       be;
    } cmd_t;

    cmd_t                         mem_q [DEPTH];
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [PW:0]                  count_q, count_d;
    state_t                       state_q, state_d;
    cmd_t                         cmd_q, cmd_d;
    logic [TW-1:0]                timer_q, timer_d;
    logic                         err_q, err_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic [PORT_OUTPUT_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic full, empty, push, pop, done;

    assign full      = (count_q == (PW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;

    // A completion is accepted in ISSUE as well as in WAIT; stray p_ready in IDLE is ignored.
    assign done = p_ready && ((state_q == ISSUE) || (state_q == WAIT));

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_t'({req_we, req_addr, req_data, req_be});
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        timer_d     = timer_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        pop         = 1'b0;
        p_wr        = 1'b0;
        p_rd        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && p_available) begin
                    pop     = 1'b1;
                    cmd_d   = mem_q[rd_ptr_q];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                p_wr    = cmd_q.we;
                p_rd    = !cmd_q.we;
                timer_d = '0;
                state_d = p_ready ? IDLE : WAIT;
            end
            WAIT: begin
                if (p_ready) begin
                    state_d = IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (done && !cmd_q.we) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = p_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            cmd_q       <= '0;
            timer_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign p_addr      = cmd_q.addr;
    assign p_data      = cmd_q.data;
    assign p_byte_en   = cmd_q.be;
    assign level       = count_q;
    assign busy        = !empty || (state_q != IDLE);
    assign err_timeout = err_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_sdram_port_req_queue.sv
// Bench for sdram_port_req_queue: a behavioural controller model answers strobes
// after a chosen delay; commands and responses are compared against queues.
module tb_sdram_port_req_queue;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int OW = 32;
    localparam int DEPTH = 4;
    localparam int TO = 8;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } cmd_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [BW-1:0] req_be;
    logic          rsp_valid;
    logic [OW-1:0] rsp_data;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    logic [BW-1:0] p_byte_en;
    logic          p_wr, p_rd;
    logic [OW-1:0] p_q = '0;
    logic          p_available;
    logic          p_ready = 1'b0;
    logic [LW-1:0] level;
    logic          busy, err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdram_port_req_queue #(
        .PORT_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DQM_WIDTH(BW),
        .PORT_OUTPUT_WIDTH(OW), .DEPTH(DEPTH), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .p_addr(p_addr), .p_data(p_data), .p_byte_en(p_byte_en),
        .p_wr(p_wr), .p_rd(p_rd), .p_q(p_q),
        .p_available(p_available), .p_ready(p_ready),
        .level(level), .busy(busy), .err_timeout(err_timeout)
    );

    // Controller model and observers, evaluated on the falling edge.
    cmd_t          exp_cmd[$], obs_cmd[$];
    logic [OW-1:0] exp_rsp[$], obs_rsp[$], pq_vals[$];
    int            obs_cyc[$];
    int            ctrl_delay = -1;
    int            cnt = 0, mcyc = 0;
    bit            ctl_active = 0, pend_ok = 0, pend_rd = 0, rsp_due = 0;
    cmd_t          held;
    int            mon_both = 0, mon_hold = 0, mon_rsp = 0;

    always @(negedge clk) begin
        mcyc++;
        if (reset_n === 1'b1 && rsp_valid !== rsp_due) mon_rsp++;
        if (rsp_valid === 1'b1) obs_rsp.push_back(rsp_data);
        rsp_due = 0;
        p_ready = 1'b0;
        if (reset_n !== 1'b1) pend_ok = 0;
        if (ctl_active && pend_ok && cmd_t'({held.we, p_addr, p_data, p_byte_en}) !== held) mon_hold++;
        if (p_wr === 1'b1 && p_rd === 1'b1) mon_both++;
        if (p_wr === 1'b1 || p_rd === 1'b1) begin
            held = cmd_t'({p_wr, p_addr, p_data, p_byte_en});
            obs_cmd.push_back(held);
            obs_cyc.push_back(mcyc);
            pend_rd = p_rd;
            pend_ok = 1;
            ctl_active = (ctrl_delay >= 0);
            cnt = ctrl_delay;
        end
        if (ctl_active) begin
            if (cnt == 0) begin
                p_ready = 1'b1;
                p_q = (pq_vals.size() != 0) ? pq_vals.pop_front() : OW'($urandom);
                if (pend_ok && pend_rd) begin
                    exp_rsp.push_back(p_q);
                    rsp_due = 1;
                end
                pend_ok = 0;
                ctl_active = 0;
            end else begin
                cnt--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_cmd.delete(); obs_cmd.delete(); exp_rsp.delete(); obs_rsp.delete();
        obs_cyc.delete(); pq_vals.delete();
        mon_both = 0; mon_hold = 0; mon_rsp = 0;
    endtask

    task automatic push_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] be, output bit acc);
        req_valid = 1'b1; req_we = we; req_addr = a; req_data = d; req_be = be;
        acc = req_ready;
        tick();
        req_valid = 1'b0;
        if (acc) exp_cmd.push_back(cmd_t'({we, a, d, be}));
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 300; k++) begin
            tick();
            if (busy === 1'b0 && !ctl_active) break;
        end
        if (k == 300) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, k);
        end
        tick(); tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({p_wr, p_rd, p_addr, p_data, p_byte_en, rsp_valid, rsp_data, err_timeout, busy, req_ready, level}
            !== {2'b00, 12'h0, 16'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL reset_state: wr=%b rd=%b addr=%h data=%h be=%b rv=%b rd=%h err=%b busy=%b rdy=%b lvl=%0d",
                     p_wr, p_rd, p_addr, p_data, p_byte_en, rsp_valid, rsp_data, err_timeout, busy, req_ready, level);
        end
        tick(); tick();
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset: ready=%b busy=%b, required 1/0", req_ready, busy);
        end
    endtask

    task automatic test_single_read();
        bit acc;
        clear_sb();
        p_available = 1'b1; ctrl_delay = 5;
        pq_vals.push_back(32'hDEADBEEF);
        push_cmd(1'b0, 12'h123, 16'h0000, 2'b00, acc);
        tick();
        n_cmp++;
        if (p_rd !== 1'b1 || p_wr !== 1'b0 || p_addr !== 12'h123) begin
            n_err++;
            $display("FAIL rd_strobe_latency: rd=%b wr=%b addr=%h, required 1/0/123", p_rd, p_wr, p_addr);
        end
        wait_idle();
        n_cmp++;
        if (obs_cmd.size() !== 1 || obs_cmd[0] !== cmd_t'({1'b0, 12'h123, 16'h0, 2'b00})) begin
            n_err++;
            $display("FAIL rd_cmd: %0d strobes, first=%h, required 1 read of 123", obs_cmd.size(), obs_cmd[0]);
        end
        n_cmp++;
        if (obs_rsp.size() !== 1 || obs_rsp[0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL rd_rsp: %0d rsp, first=%h, required 1 of DEADBEEF", obs_rsp.size(), obs_rsp[0]);
        end
        n_cmp++;
        if (mon_rsp !== 0 || rsp_data !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL rd_rsp_timing: %0d timing errors, held data=%h, required 0/DEADBEEF", mon_rsp, rsp_data);
        end
    endtask

    task automatic test_write();
        bit acc;
        clear_sb();
        p_available = 1'b1; ctrl_delay = 4;
        push_cmd(1'b1, 12'h010, 16'hA5A5, 2'b01, acc);
        wait_idle();
        n_cmp++;
        if (obs_cmd.size() !== 1 || obs_cmd[0] !== cmd_t'({1'b1, 12'h010, 16'hA5A5, 2'b01})) begin
            n_err++;
            $display("FAIL wr_cmd: %0d strobes, first=%h, required 1 write 010/A5A5/01", obs_cmd.size(), obs_cmd[0]);
        end
        n_cmp++;
        if (obs_rsp.size() !== 0 || mon_rsp !== 0 || mon_hold !== 0) begin
            n_err++;
            $display("FAIL wr_no_rsp: rsp=%0d timing=%0d hold=%0d, required 0/0/0", obs_rsp.size(), mon_rsp, mon_hold);
        end
    endtask

    task automatic test_fill();
        bit acc;
        clear_sb();
        p_available = 1'b0; ctrl_delay = 2;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (req_ready !== (i < DEPTH)) begin
                n_err++;
                $display("FAIL fill_ready_%0d: ready=%b, required %b", i, req_ready, (i < DEPTH));
            end
            push_cmd(i[0], AW'(12'h200 + i), DW'(16'h1000 + i), 2'b11, acc);
            n_cmp++;
            if (level !== LW'((i < DEPTH) ? i + 1 : DEPTH)) begin
                n_err++;
                $display("FAIL fill_level_%0d: level=%0d, required %0d", i, level, (i < DEPTH) ? i + 1 : DEPTH);
            end
        end
        n_cmp++;
        if (obs_cmd.size() !== 0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL fill_hold_off: %0d issued busy=%b, required 0/1", obs_cmd.size(), busy);
        end
        p_available = 1'b1;
        wait_idle();
        n_cmp++;
        if (obs_cmd.size() !== DEPTH) begin
            n_err++;
            $display("FAIL fill_count: %0d issued, required %0d", obs_cmd.size(), DEPTH);
        end
        for (int i = 0; i < obs_cmd.size() && i < DEPTH; i++) begin
            n_cmp++;
            if (obs_cmd[i].addr !== AW'(12'h200 + i) || obs_cmd[i] !== exp_cmd[i]) begin
                n_err++;
                $display("FAIL fill_order_%0d: got %h, required %h", i, obs_cmd[i], exp_cmd[i]);
            end
        end
    endtask

    task automatic test_mixed();
        bit acc;
        clear_sb();
        p_available = 1'b0; ctrl_delay = 1;
        pq_vals.push_back(32'd1); pq_vals.push_back(32'd2); pq_vals.push_back(32'd3);
        push_cmd(1'b0, 12'h0A0, 16'h0, 2'b00, acc);
        push_cmd(1'b1, 12'h0B0, 16'hBEEF, 2'b10, acc);
        push_cmd(1'b0, 12'h0C0, 16'h0, 2'b00, acc);
        p_available = 1'b1;
        wait_idle();
        n_cmp++;
        if (obs_cmd.size() !== 3 || obs_cmd[0].we !== 1'b0 || obs_cmd[1].we !== 1'b1 || obs_cmd[2].we !== 1'b0
            || obs_cmd[0].addr !== 12'h0A0 || obs_cmd[1].addr !== 12'h0B0 || obs_cmd[2].addr !== 12'h0C0) begin
            n_err++;
            $display("FAIL mixed_order: %0d strobes %h %h %h, required rd A0, wr B0, rd C0",
                     obs_cmd.size(), obs_cmd[0], obs_cmd[1], obs_cmd[2]);
        end
        n_cmp++;
        if (obs_rsp.size() !== 2 || obs_rsp[0] !== 32'd1 || obs_rsp[1] !== 32'd3) begin
            n_err++;
            $display("FAIL mixed_rsp: %0d rsp %h %h, required 1 then 3", obs_rsp.size(), obs_rsp[0], obs_rsp[1]);
        end
        n_cmp++;
        if (obs_cyc.size() !== 3 || obs_cyc[1] - obs_cyc[0] !== 3 || obs_cyc[2] - obs_cyc[1] !== 3) begin
            n_err++;
            $display("FAIL mixed_spacing: gaps %0d %0d, required 3 3", obs_cyc[1] - obs_cyc[0], obs_cyc[2] - obs_cyc[1]);
        end
        n_cmp++;
        if (mon_both !== 0 || mon_rsp !== 0) begin
            n_err++;
            $display("FAIL mixed_strobes: both=%0d timing=%0d, required 0/0", mon_both, mon_rsp);
        end
    endtask

    task automatic test_timeout();
        bit acc;
        int k;
        clear_sb();
        p_available = 1'b1; ctrl_delay = -1;
        push_cmd(1'b0, 12'h0AA, 16'h0, 2'b00, acc);
        push_cmd(1'b1, 12'h0BB, 16'h1234, 2'b11, acc);
        for (k = 0; k < 10 && p_rd !== 1'b1; k++) tick();
        tick();
        ctrl_delay = 1;
        for (int i = 0; i < TO - 1; i++) tick();
        n_cmp++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_early: err=%b busy=%b one cycle before limit, required 0/1", err_timeout, busy);
        end
        tick();
        n_cmp++;
        if (err_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_flag: err=%b, required 1", err_timeout);
        end
        tick();
        n_cmp++;
        if (p_wr !== 1'b1 || p_addr !== 12'h0BB) begin
            n_err++;
            $display("FAIL timeout_next: wr=%b addr=%h, required 1/0BB", p_wr, p_addr);
        end
        wait_idle();
        n_cmp++;
        if (obs_cmd.size() !== 2 || obs_rsp.size() !== 0 || err_timeout !== 1'b1 || mon_rsp !== 0) begin
            n_err++;
            $display("FAIL timeout_after: cmds=%0d rsp=%0d err=%b timing=%0d, required 2/0/1/0",
                     obs_cmd.size(), obs_rsp.size(), err_timeout, mon_rsp);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit acc;
        int k;
        clear_sb();
        p_available = 1'b1; ctrl_delay = 4;
        push_cmd(1'b0, 12'h055, 16'h0, 2'b00, acc);
        push_cmd(1'b1, 12'h066, 16'h7777, 2'b01, acc);
        for (k = 0; k < 10 && p_rd !== 1'b1; k++) tick();
        tick(); tick();
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({p_wr, p_rd, p_addr, p_data, p_byte_en, rsp_valid, rsp_data, err_timeout, busy, req_ready, level}
            !== {2'b00, 12'h0, 16'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL midwait_reset: wr=%b rd=%b addr=%h data=%h be=%b rv=%b rd=%h err=%b busy=%b rdy=%b lvl=%0d",
                     p_wr, p_rd, p_addr, p_data, p_byte_en, rsp_valid, rsp_data, err_timeout, busy, req_ready, level);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_cmp++;
        if (obs_rsp.size() !== 0 || obs_cmd.size() !== 1 || busy !== 1'b0 || mon_rsp !== 0) begin
            n_err++;
            $display("FAIL midwait_after: rsp=%0d cmds=%0d busy=%b timing=%0d, required 0/1/0/0",
                     obs_rsp.size(), obs_cmd.size(), busy, mon_rsp);
        end
    endtask

    task automatic test_random();
        int  sent = 0;
        bit  acc;
        clear_sb();
        for (int cyc = 0; cyc < 4000 && sent < 60; cyc++) begin
            p_available = ($urandom_range(0, 3) != 0);
            ctrl_delay  = $urandom_range(0, 5);
            if (req_valid !== 1'b1 && $urandom_range(0, 1) == 1) begin
                req_valid = 1'b1;
                req_we    = 1'($urandom);
                req_addr  = AW'($urandom);
                req_data  = DW'($urandom);
                req_be    = BW'($urandom);
            end
            acc = req_valid && req_ready;
            tick();
            if (acc) begin
                exp_cmd.push_back(cmd_t'({req_we, req_addr, req_data, req_be}));
                sent++;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        p_available = 1'b1;
        wait_idle();
        n_cmp++;
        if (obs_cmd.size() !== exp_cmd.size() || sent !== 60) begin
            n_err++;
            $display("FAIL rand_count: issued %0d of %0d accepted (sent %0d), required equal and 60",
                     obs_cmd.size(), exp_cmd.size(), sent);
        end
        for (int i = 0; i < obs_cmd.size() && i < exp_cmd.size(); i++) begin
            n_cmp++;
            if (obs_cmd[i] !== exp_cmd[i]) begin
                n_err++;
                $display("FAIL rand_cmd_%0d: got %h, required %h", i, obs_cmd[i], exp_cmd[i]);
            end
        end
        n_cmp++;
        if (obs_rsp.size() !== exp_rsp.size()) begin
            n_err++;
            $display("FAIL rand_rsp_count: %0d rsp, required %0d", obs_rsp.size(), exp_rsp.size());
        end
        for (int i = 0; i < obs_rsp.size() && i < exp_rsp.size(); i++) begin
            n_cmp++;
            if (obs_rsp[i] !== exp_rsp[i]) begin
                n_err++;
                $display("FAIL rand_rsp_%0d: got %h, required %h", i, obs_rsp[i], exp_rsp[i]);
            end
        end
        n_cmp++;
        if (mon_both !== 0 || mon_hold !== 0 || mon_rsp !== 0 || level !== 3'd0 || err_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL rand_protocol: both=%0d hold=%0d timing=%0d level=%0d err=%b, required all 0",
                     mon_both, mon_hold, mon_rsp, level, err_timeout);
        end
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; req_be = '0;
        p_available = 1'b0;
        test_reset();
        test_single_read();
        test_write();
        test_fill();
        test_mixed();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
